// File: rtl/alu_accum_seq.sv
// alu_accum_seq
// Accumulator-style front end for the 32-bit combinational ALU. Commands are
// buffered in a small FIFO and issued one at a time. Each command runs the
// ALU with the accumulator as operand A, then writes the result back.
// A load command bypasses the ALU result and writes its operand directly.
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on registered FIFO state.
// res_valid is a single-cycle pulse that follows every accumulator update.
//
// Ports:
//   clk, rst (sync, active-low), clr (sync, active-high, below rst)
//   cmd_valid/cmd_ready/cmd_op/cmd_load/cmd_operand : command input
//   alu_a/alu_b/alu_sel  : drive the ALU inputs
//   alu_out/alu_zero     : ALU result and zero flag
//   acc/acc_zero/res_valid : accumulator, its zero flag, update strobe
//   busy      : work in flight or queued
//   op_count  : completed commands, wraps
//   fsm_state : 0 = IDLE, 1 = EXEC (debug visibility)
module alu_accum_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [31:0]      cmd_operand,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  output logic [31:0]      acc,
  output logic             acc_zero,
  output logic             res_valid,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             fsm_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        state;
  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          iss_load;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          flush;
  logic [36:0]   head;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign flush     = !rst || clr;
  assign head      = mem[rd_ptr];

  // Operand A is the accumulator itself; B and select are the issue registers.
  assign alu_a     = acc;
  assign busy      = (state != IDLE) || !empty;
  assign fsm_state = (state == EXEC);

  // Storage has no reset; pointers define what is valid. A push coinciding
  // with reset or clear is dropped.
  always_ff @(posedge clk) begin
    if (!flush && push) begin
      mem[wr_ptr] <= {cmd_load, cmd_op, cmd_operand};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      iss_load  <= 1'b0;
      alu_b     <= '0;
      alu_sel   <= '0;
      acc       <= '0;
      acc_zero  <= 1'b1;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      res_valid <= 1'b0;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            iss_load <= head[36];
            alu_sel  <= head[35:32];
            alu_b    <= head[31:0];
            state    <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable all cycle; capture its result now.
          acc       <= iss_load ? alu_b : alu_out;
          acc_zero  <= iss_load ? (alu_b == 32'd0) : alu_zero;
          op_count  <= op_count + 1'b1;
          res_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq with a behavioural ALU attached to its ALU ports.
// Drivers push commands with hand-computed expected accumulator values into
// exp_q; a monitor pops and compares on every res_valid pulse.
module tb_alu_accum_seq;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic        cmd_load = 1'b0;
  logic [31:0] cmd_operand = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [31:0] acc;
  logic        acc_zero;
  logic        res_valid;
  logic        busy;
  logic [7:0]  op_count;
  logic        fsm_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // {op_count, acc_zero, acc}
  logic [40:0] exp_q[$];
  logic [7:0]  m_cnt = '0;

  logic prev_rv = 1'b0;
  bit   spc_en = 0;
  bit   spc_have = 0;
  int   last_cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_accum_seq #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_load(cmd_load), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .acc(acc), .acc_zero(acc_zero), .res_valid(res_valid),
    .busy(busy), .op_count(op_count), .fsm_state(fsm_state)
  );

  // Behavioural ALU
  always_comb begin
    case (alu_sel)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic ld, input logic [3:0] op, input logic [31:0] b,
                          input logic [31:0] exp_acc, output int stalls);
    stalls = 0;
    cmd_valid = 1'b1;
    cmd_load = ld;
    cmd_op = op;
    cmd_operand = b;
    while (cmd_ready !== 1'b1 && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    m_cnt = m_cnt + 8'd1;
    exp_q.push_back({m_cnt, (exp_acc == 32'd0), exp_acc});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b pending=%0d expected 0", busy, exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [40:0] e;
    if (res_valid === 1'b1) begin
      chk("res_valid_single_cycle", {63'd0, prev_rv}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: acc=%0h expected no result", acc);
      end else begin
        e = exp_q.pop_front();
        chk("result", {23'd0, op_count, acc_zero, acc}, {23'd0, e});
      end
      if (spc_en) begin
        if (spc_have) chk("result_spacing", 64'(cyc - last_cyc), 64'd2);
        spc_have = 1;
        last_cyc = cyc;
      end
    end
    prev_rv = res_valid;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic        ld_t [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0]  op_t [10] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_ADD};
  logic [31:0] b_t  [10] = '{32'd100, 32'd1, 32'd2, 32'd3, 32'd10, 32'd110, 32'd7, 32'd8, 32'd20, 32'd5};
  logic [31:0] ex_t [10] = '{32'd100, 32'd101, 32'd103, 32'd100, 32'd110, 32'd0, 32'd7, 32'd15,
                             32'hFFFF_FFFB, 32'd0};
  int          st_t [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    int st;
    int n;
    logic [31:0] v;

    // 1: reset values, load 12, add 11
    do_reset();
    chk("rst_acc", {32'd0, acc}, 64'd0);
    chk("rst_acc_zero", {63'd0, acc_zero}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_op_count", {56'd0, op_count}, 64'd0);
    chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
    chk("rst_alu_sel", {60'd0, alu_sel}, 64'd0);

    push_cmd(1'b1, OP_ADD, 32'd12, 32'd12, st);
    n = 0;
    while (res_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_result_latency", 64'(n), 64'd2);
    @(negedge clk);
    chk("res_valid_pulse_width", {63'd0, res_valid}, 64'd0);
    push_cmd(1'b0, OP_ADD, 32'd11, 32'd23, st);
    wait_idle();
    chk("t1_acc", {32'd0, acc}, 64'd23);
    chk("t1_acc_zero", {63'd0, acc_zero}, 64'd0);
    chk("t1_op_count", {56'd0, op_count}, 64'd2);

    // 2: subtract to zero, add with 32-bit wrap
    push_cmd(1'b1, OP_ADD, 32'd5, 32'd5, st);
    push_cmd(1'b0, OP_SUB, 32'd5, 32'd0, st);
    push_cmd(1'b1, OP_ADD, 32'd1, 32'd1, st);
    push_cmd(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd0, st);
    wait_idle();
    chk("t2_acc", {32'd0, acc}, 64'd0);
    chk("t2_acc_zero", {63'd0, acc_zero}, 64'd1);
    chk("t2_op_count", {56'd0, op_count}, 64'd6);

    // 3: back-to-back stream that fills the FIFO
    spc_en = 1;
    spc_have = 0;
    for (int i = 0; i < 10; i++) begin
      push_cmd(ld_t[i], op_t[i], b_t[i], ex_t[i], st);
      chk($sformatf("t3_stall_%0d", i), 64'(st), 64'(st_t[i]));
      if (i == 6) chk("t3_full_ready_low", {63'd0, cmd_ready}, 64'd0);
    end
    wait_idle();
    spc_en = 0;
    chk("t3_acc", {32'd0, acc}, 64'd0);
    chk("t3_op_count", {56'd0, op_count}, 64'd16);

    // 4: reset while a command executes; simultaneous push dropped
    do_reset();
    push_cmd(1'b0, OP_ADD, 32'd9, 32'd9, st);
    @(negedge clk);
    chk("t4_in_exec", {63'd0, fsm_state}, 64'd1);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = '0;
    cmd_valid = 1'b1;
    cmd_load = 1'b0;
    cmd_op = OP_ADD;
    cmd_operand = 32'd50;
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    chk("t4_acc", {32'd0, acc}, 64'd0);
    chk("t4_res_valid", {63'd0, res_valid}, 64'd0);
    chk("t4_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("t4_acc_hold", {32'd0, acc}, 64'd0);
    push_cmd(1'b0, OP_ADD, 32'd4, 32'd4, st);
    push_cmd(1'b0, OP_SUB, 32'd1, 32'd3, st);
    wait_idle();
    chk("t4_after_acc", {32'd0, acc}, 64'd3);
    chk("t4_after_op_count", {56'd0, op_count}, 64'd2);

    // 5: clear with three commands queued
    push_cmd(1'b1, OP_ADD, 32'd23, 32'd23, st);
    wait_idle();
    push_cmd(1'b0, OP_ADD, 32'd0, 32'd23, st);
    push_cmd(1'b0, OP_ADD, 32'd0, 32'd23, st);
    push_cmd(1'b0, OP_ADD, 32'd1, 32'd24, st);
    push_cmd(1'b0, OP_ADD, 32'd1, 32'd25, st);
    push_cmd(1'b0, OP_ADD, 32'd1, 32'd26, st);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    m_cnt = '0;
    chk("t5_acc", {32'd0, acc}, 64'd0);
    chk("t5_acc_zero", {63'd0, acc_zero}, 64'd1);
    chk("t5_op_count", {56'd0, op_count}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (6) @(negedge clk);
    chk("t5_acc_hold", {32'd0, acc}, 64'd0);

    // 6: 256 loads wrap op_count
    for (int i = 0; i < 256; i++) begin
      v = 32'(i * 7 + 3);
      push_cmd(1'b1, OP_ADD, v, v, st);
    end
    wait_idle();
    chk("t6_op_count_wrap", {56'd0, op_count}, 64'd0);
    chk("t6_acc", {32'd0, acc}, 64'd1788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
